// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit-side arbiter.
// The default byte width matches the UART core.
package uart_tx_arbiter_pkg;

    localparam int DBIT_DEFAULT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: first set request after last_idx, wrapping modulo N_REQ.
// The result is returned both as a one-hot vector and as an index.
module uart_tx_arbiter_rr
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_idx,
    output logic [N_REQ-1:0] onehot,
    output logic [IW-1:0]    idx
);

    logic [IW-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        cand   = '0;
        // Walk from farthest to nearest so the nearest request after last_idx wins.
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IW'((int'(last_idx) + k) % N_REQ);
            if (req[cand]) begin
                onehot       = '0;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART TX FIFO write port between N_REQ byte streams, one whole frame per grant,
// round-robin, with a stall watchdog that revokes the grant from an owner that stops sending.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int DBIT    = DBIT_DEFAULT,
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DBIT-1:0]       req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_ready,
    output logic [DBIT-1:0]             w_data,
    output logic                        wr_uart,
    input  logic                        tx_full,
    output logic [N_REQ-1:0]            grant,
    output logic                        busy,
    output logic                        timeout_err,
    output logic [idx_width(N_REQ)-1:0] timeout_id
);

    localparam int IW = idx_width(N_REQ);
    localparam int CW = idx_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);

    arb_state_t       state_reg, state_next;
    logic [IW-1:0]    gidx_reg, gidx_next;
    logic [IW-1:0]    last_idx_reg, last_idx_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [IW-1:0]    timeout_id_reg, timeout_id_next;
    logic [N_REQ-1:0] arb_onehot;
    logic [IW-1:0]    arb_idx;
    logic [DBIT-1:0]  data_arr [N_REQ];
    logic             sel_valid, sel_last, stall;

    uart_tx_arbiter_rr #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr (
        .req      (req_valid),
        .last_idx (last_idx_reg),
        .onehot   (arb_onehot),
        .idx      (arb_idx)
    );

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign data_arr[gi]  = req_data[gi*DBIT +: DBIT];
            assign grant[gi]     = busy && (gidx_reg == IW'(gi));
            assign req_ready[gi] = grant[gi] && !tx_full;
        end
    endgenerate

    assign busy       = (state_reg == BUSY);
    assign sel_valid  = req_valid[gidx_reg];
    assign sel_last   = req_last[gidx_reg];
    assign wr_uart    = busy && sel_valid && !tx_full;
    assign w_data     = busy ? data_arr[gidx_reg] : '0;
    // A full FIFO is back-pressure, not a stalled owner.
    assign stall      = busy && !sel_valid && !tx_full;
    assign timeout_id = timeout_id_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            gidx_reg       <= '0;
            last_idx_reg   <= IW'(N_REQ - 1);
            cnt_reg        <= '0;
            timeout_id_reg <= '0;
        end else begin
            state_reg      <= state_next;
            gidx_reg       <= gidx_next;
            last_idx_reg   <= last_idx_next;
            cnt_reg        <= cnt_next;
            timeout_id_reg <= timeout_id_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        gidx_next       = gidx_reg;
        last_idx_next   = last_idx_reg;
        cnt_next        = cnt_reg;
        timeout_id_next = timeout_id_reg;
        timeout_err     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|arb_onehot) begin
                    state_next = BUSY;
                    gidx_next  = arb_idx;
                    cnt_next   = '0;
                end
            end
            BUSY: begin
                if (wr_uart) begin
                    cnt_next = '0;
                    if (sel_last) begin
                        state_next    = IDLE;
                        last_idx_next = gidx_reg;
                    end
                end else if (stall) begin
                    if (cnt_reg == CNT_LIMIT) begin
                        state_next      = IDLE;
                        last_idx_next   = gidx_reg;
                        timeout_err     = 1'b1;
                        timeout_id_next = gidx_reg;
                        cnt_next        = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues drive bytes, a negedge monitor
// checks every FIFO write against the expected byte/owner order.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           clk;
    logic           reset_n;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     w_data;
    logic           wr_uart;
    logic           tx_full;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout_err;
    logic [1:0]     timeout_id;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q [$];
    logic [8:0] src_q [N][$];
    logic [N-1:0] fire_s;
    logic       tmo_ok;
    int         checks;
    int         errors;

    uart_tx_arbiter #(
        .DBIT    (8),
        .N_REQ   (N),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .w_data      (w_data),
        .wr_uart     (wr_uart),
        .tx_full     (tx_full),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err),
        .timeout_id  (timeout_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        logic [8:0] h;
        for (int r = 0; r < N; r++) begin
            if (src_q[r].size() != 0) begin
                h = src_q[r][0];
                req_valid[r]       = 1'b1;
                req_data[r*8 +: 8] = h[7:0];
                req_last[r]        = h[8];
            end else begin
                req_valid[r]       = 1'b0;
                req_data[r*8 +: 8] = 8'h00;
                req_last[r]        = 1'b0;
            end
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic last);
        exp_t e;
        src_q[r].push_back({last, d});
        e.id   = r;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_exp(input string name, input int target);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (exp_q.size() != target && n < 100);
        chk(name, exp_q.size(), target);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic check_pattern(input string name, input logic [4:0] exp_wr, input logic [4:0] exp_busy);
        logic [4:0] wr_p;
        logic [4:0] busy_p;
        for (int i = 4; i >= 0; i--) begin
            @(negedge clk);
            wr_p[i]   = wr_uart;
            busy_p[i] = busy;
        end
        chk({name, "_wr_pattern"}, 32'(wr_p), 32'(exp_wr));
        chk({name, "_busy_pattern"}, 32'(busy_p), 32'(exp_busy));
    endtask

    // Monitor: compares every FIFO write against the scoreboard and latches handshakes.
    always @(negedge clk) begin
        exp_t e;
        logic [N-1:0] eg;
        fire_s = req_valid & req_ready;
        if (reset_n) begin
            if (wr_uart) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write: unexpected byte %02h grant %b", w_data, grant);
                end else begin
                    e  = exp_q.pop_front();
                    eg = N'(1 << e.id);
                    if (w_data !== e.data || grant !== eg) begin
                        errors++;
                        $display("FAIL write: got byte %02h grant %b expected byte %02h grant %b",
                                 w_data, grant, e.data, eg);
                    end
                end
            end
            if (timeout_err && !tmo_ok) begin
                checks++;
                errors++;
                $display("FAIL timeout_err: got 1 expected 0 (id %0d)", timeout_id);
            end
        end
    end

    // Requester side: retire accepted bytes, then present the next one.
    always @(posedge clk) begin
        #1;
        for (int r = 0; r < N; r++) begin
            if (fire_s[r] && src_q[r].size() != 0) void'(src_q[r].pop_front());
        end
        fire_s = '0;
        drive();
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int k;
        int nw;
        int nr;
        checks  = 0;
        errors  = 0;
        tmo_ok  = 1'b0;
        fire_s  = '0;
        tx_full = 1'b0;
        reset_n = 1'b0;
        drive();

        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_uart", wr_uart, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_timeout_id", timeout_id, 0);
        chk("rst_req_ready", req_ready, 0);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Single requester frame on req 2.
        #2;
        push(2, 8'h11, 1'b0);
        push(2, 8'h22, 1'b0);
        push(2, 8'h33, 1'b1);
        check_pattern("single", 5'b01110, 5'b01110);
        wait_drain("single_drain");
        chk("single_grant_idle", grant, 0);

        // Watchdog on req 3: one byte without last, then silence.
        @(negedge clk);
        #2;
        tmo_ok = 1'b1;
        push(3, 8'h3C, 1'b0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!wr_uart && k < 20);
        chk("wd_write_seen", wr_uart, 1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!timeout_err && k < 40);
        chk("wd_delay", k, 16);
        @(negedge clk);
        chk("wd_timeout_id", timeout_id, 3);
        chk("wd_pulse_width", timeout_err, 0);
        chk("wd_released", busy, 0);
        tmo_ok = 1'b0;

        // Fairness: all requesters busy, req 0 has a second frame queued.
        #2;
        push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1);
        push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b1);
        push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1);
        push(3, 8'hD0, 1'b0); push(3, 8'hD1, 1'b1);
        push(0, 8'hE0, 1'b0); push(0, 8'hE1, 1'b1);
        wait_drain("fair_drain");

        // Back-pressure: FIFO full for 2000 cycles after byte 2 of a req 1 frame.
        @(negedge clk);
        #2;
        push(1, 8'hF1, 1'b0);
        push(1, 8'hF2, 1'b0);
        push(1, 8'hF3, 1'b0);
        push(1, 8'hF4, 1'b1);
        wait_exp("bp_two_written", 2);
        @(posedge clk);
        #2 tx_full = 1'b1;
        nw = 0;
        nr = 0;
        repeat (2000) begin
            @(negedge clk);
            if (wr_uart) nw++;
            if (req_ready != 0) nr++;
        end
        chk("bp_no_write", nw, 0);
        chk("bp_no_ready", nr, 0);
        chk("bp_still_busy", busy, 1);
        @(posedge clk);
        #2 tx_full = 1'b0;
        wait_drain("bp_drain");

        // Asynchronous reset in the middle of a req 0 frame.
        @(negedge clk);
        #2;
        push(0, 8'h01, 1'b0);
        push(0, 8'h02, 1'b0);
        push(0, 8'h03, 1'b0);
        push(0, 8'h04, 1'b1);
        wait_exp("ar_two_written", 2);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("ar_grant", grant, 0);
        chk("ar_wr_uart", wr_uart, 0);
        chk("ar_busy", busy, 0);
        chk("ar_timeout_id", timeout_id, 0);
        for (int r = 0; r < N; r++) src_q[r].delete();
        exp_q.delete();
        fire_s = '0;
        drive();
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        #2;
        push(0, 8'h66, 1'b1);
        push(2, 8'h77, 1'b1);
        wait_drain("ar_priority_drain");

        // Single-byte frames from req 0 and req 1.
        @(negedge clk);
        #2;
        push(0, 8'hA5, 1'b1);
        push(1, 8'h5A, 1'b1);
        check_pattern("onebyte", 5'b01010, 5'b01010);
        wait_drain("onebyte_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the UART transmit FIFO write port (w_data / wr_uart / tx_full) between N_REQ independent byte-stream requesters.
- Grants the port one whole frame at a time: bytes from one requester up to and including its last byte are never interleaved with another's.
- Uses round-robin arbitration, so every active requester is served in turn.
- A stall watchdog releases the grant if the owning requester stops supplying bytes mid-frame.

Parameters:
- DBIT, 8, data byte width; must match the UART DBIT.
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 1024, number of consecutive stalled cycles in BUSY before the grant is revoked (>=2).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  N_REQ  per-requester byte available
- req_data  input  N_REQ*DBIT  requester i byte on bits [i*DBIT +: DBIT]
- req_last  input  N_REQ  per-requester: current byte ends the frame
- req_ready  output  N_REQ  per-requester: byte accepted this cycle when valid & ready
- w_data  output  DBIT  byte to the UART TX FIFO
- wr_uart  output  1  TX FIFO write strobe
- tx_full  input  1  TX FIFO full
- grant  output  N_REQ  one-hot current owner; all zero in IDLE
- busy  output  1  a frame is in progress (state BUSY)
- timeout_err  output  1  one-cycle pulse when a grant is revoked by the watchdog
- timeout_id  output  clog2(N_REQ)  index of the revoked requester; held until the next timeout

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, grant=0, busy=0, timeout_err=0, timeout_id=0.
  - Round-robin pointer last_idx=N_REQ-1, so requester 0 has first priority.
  - Stall counter=0.
- IDLE:
  - If any req_valid is set, pick the first set index searching last_idx+1, last_idx+2, ... (modulo N_REQ).
  - Register it as gidx and move to BUSY on the next edge. Arbitration latency is 1 cycle. No transfer occurs in IDLE.
  - If no req_valid is set, stay in IDLE.
- BUSY (owner gidx):
  - req_ready[gidx] = ~tx_full; all other req_ready bits = 0. Combinational.
  - wr_uart = req_valid[gidx] & ~tx_full. w_data = req_data[gidx]. Combinational, zero latency.
  - A transfer happens when wr_uart=1.
  - Transfer with req_last[gidx]=1: last_idx<=gidx, state<=IDLE. The next frame's grant is therefore at least 1 cycle later.
  - Stall counter: cleared on every transfer; incremented on every BUSY cycle where req_valid[gidx]=0.
  - Cycles with tx_full=1 are back-pressure, not stalls: the counter holds.
  - When the counter reaches TIMEOUT-1 while still stalled:
    - state<=IDLE, last_idx<=gidx.
    - timeout_err pulses 1 cycle; timeout_id<=gidx.
    - The counter is cleared.
    - Bytes already written stay in the FIFO; no recovery byte is inserted.
- In IDLE, grant=0, wr_uart=0 and req_ready=0 always.
- Simultaneous events:
  - Last-byte transfer and watchdog expiry cannot coincide, because a transfer clears the counter.
  - A requester deasserting req_valid while granted is legal and counts as a stall.
  - Requesters not granted may change req_valid freely; the arbiter samples only in IDLE.
- A requester may present a single-byte frame (valid & last in the same cycle).
- Reset mid-frame aborts immediately: outputs return to reset values and the partial frame stays in the FIFO.
- busy = (state==BUSY).

Decomposition:
- Shared uart package:
  - state encoding constants IDLE/BUSY
  - function for clog2 index width
  - DBIT default shared with uart
- Natural sub-module: rr_arbiter. It is combinational and takes the request vector and last_idx, and produces a one-hot plus index. Reuse it for future RX demux sharing.
- The watchdog counter stays inline, width clog2(TIMEOUT).

Test Plan:
1. Single-requester frame:
   - After reset, req 2 sends frame 0x11,0x22,0x33 (last on 0x33), tx_full=0.
   - Expect grant=0100 1 cycle after valid, then 3 consecutive wr_uart with w_data=11,22,33, then IDLE and grant=0.
2. Fairness:
   - All 4 requesters hold valid, each sending 2-byte frames.
   - Expect grant order 0,1,2,3,0.
   - No interleaving: the FIFO byte stream shows each frame's bytes contiguous.
3. Back-pressure:
   - Req 1 frame of 4 bytes; tx_full held high for 2000 cycles after byte 2.
   - Expect no wr_uart while full and no timeout_err; remaining bytes are written after full drops.
4. Watchdog:
   - TIMEOUT=16. Req 3 sends 1 byte without last, then drops valid.
   - Expect timeout_err pulse exactly 16 cycles after the last transfer, with timeout_id=3.
   - Next arbitration starts from req 0.
5. Async reset mid-frame:
   - Assert reset_n=0 between bytes of a req-0 frame, off a clock edge.
   - Expect grant=0, wr_uart=0, busy=0 immediately.
   - After release, req 0 is still first priority.
6. Single-byte frames:
   - Req 0 and req 1 present valid&last with 0xA5/0x5A.
   - Expect writes A5 then 5A, each preceded by a 1-cycle arbitration gap.
